serpent_inv_lt_stage: RTL and testbench
=======================================

Name: serpent_inv_lt_stage

Overview:
Registered front half of one Serpent decryption round, directly upstream of the bitsliced inverse S-box layer. For rounds 30..0 it applies the inverse linear transform (InvLT); for round 31 it XORs subkey K32 instead. It presents four 32-bit words plus the S-box index (round mod 8) to the inverse S-box layer through a 2-entry elastic (skid) buffer with valid/ready on both sides, giving full throughput and a registered ready.

Parameters:
WORD_W, 32, word width; fixed; only 32 is supported.
ROUND_W, 5, round index width (rounds 0..31).

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input beat valid
o_ready  out  1  stage can accept a beat; registered
i_round  in  5  round index of the beat
i_key  in  128  {K32 word3..word0}; used only when i_round==31
i_word_0..i_word_3  in  32 each  state words X0..X3
i_flush  in  1  synchronous drop of all held beats
o_valid  out  1  output beat valid
i_ready  in  1  downstream (inverse S-box / key-mix) accepts
o_word_0..o_word_3  out  32 each  transformed words
o_sbox_index  out  3  i_round[2:0] of the beat; selects InvS_k downstream
o_round  out  5  round index carried with the beat
o_data  out  128  {o_word_3,o_word_2,o_word_1,o_word_0}

Behaviour:
- Datapath, combinational before capture; >>> is rotate-right, << is logical shift-left, all 32-bit:
  - round==31: Xi ^= i_key[32i+31:32i], for i = 0..3.
  - else InvLT, in order: X2>>>=22; X0>>>=5; X2=X2^X3^(X1<<7); X0=X0^X1^X3; X3>>>=7; X1>>>=1; X3=X3^X2^(X0<<3); X1=X1^X0^X2; X2>>>=3; X0>>>=13.
- Storage: main register M (drives outputs) and skid register S, each holding {words, round, valid}.
- Accept = i_valid & o_ready. Transformed data is captured, never raw data.
- Output handshake: a beat leaves when o_valid & i_ready.
  - M empty, or M leaving: an accepted beat goes to M.
  - M full and stalled (!i_ready): an accepted beat goes to S.
  - M leaving while S full: S moves to M. Any new beat lands in S only if S is simultaneously freed; o_ready already blocks it otherwise.
- o_ready = !S.valid, registered. Accept while M holds and is stalled → o_ready falls the next cycle.
- Latency: 1 cycle from accept to o_valid when empty. Throughput: 1 beat/cycle with i_ready held high.
- Ordering: strict FIFO; beats are never dropped or duplicated except by flush.
- Output stability: while o_valid & !i_ready, all o_* hold stable.
- i_flush: next edge clears M.valid and S.valid; o_ready=1. Beats presented in the flush cycle are discarded. Flush has priority over accept and move.
- Reset (async assert, sync-safe deassert handled externally):
  - o_valid=0, o_ready=1.
  - o_word_*=0, o_data=0, o_round=0, o_sbox_index=0.
  - Reset mid-transfer loses all held beats.
- o_sbox_index and o_round always equal the held beat's round fields. They are 0 when empty.
- i_round is 5 bits, so no out-of-range value exists. Only 31 selects the key path.

Decomposition:
- Shared package serpent_pkg: WORD_W, ROUND_W, LAST_ROUND=31, the rotate constants (22, 5, 7, 1, 3, 13 and shifts 7, 3), and the function inv_lt(X0..X3). The same package serves the forward LT stage.
- One natural sub-module: serpent_skid_buf, a generic 2-entry valid/ready buffer with flush, parameterised on payload width (133 = 128 data + 5 round).

Test Plan:
- Reset → o_valid=0, o_ready=1, o_data=0; then i_round=5, words {X0=0,X1=1,X2=0,X3=0}, i_ready=1 → next cycle o_word_0=0x00080000, o_word_1=0x80000081, o_word_2=0x00000010, o_word_3=0x00000088, o_sbox_index=5.
- i_round=31, all words 0, i_key=all-ones → o_data=all-ones, o_sbox_index=7, o_round=31. Same beat with i_round=30 → o_data=0 (key ignored, InvLT(0)=0).
- i_ready=0, push beats A,B → A held on outputs, B in S, o_ready=0 next cycle, third beat C not accepted. i_ready=1 → A, B, C emerge in order over consecutive cycles.
- Continuous 32-beat stream, rounds 31..0, i_ready=1 → 32 consecutive o_valid cycles, o_sbox_index sequence 7,6,...,0 repeating, outputs matching the golden model.
- M and S full, assert i_flush with i_valid=1 → next cycle o_valid=0, o_ready=1, nothing emitted. Async i_rst mid-stream → o_valid drops immediately and all outputs read 0.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared Serpent constants and the linear transform helpers used by the
// forward and inverse LT pipeline stages.
package serpent_pkg;

  localparam int WORD_W  = 32;
  localparam int ROUND_W = 5;
  localparam logic [ROUND_W-1:0] LAST_ROUND = 5'd31;

  localparam int ROT_A  = 22;
  localparam int ROT_B  = 5;
  localparam int ROT_C  = 7;
  localparam int ROT_D  = 1;
  localparam int ROT_E  = 3;
  localparam int ROT_F  = 13;
  localparam int SHL_X1 = 7;
  localparam int SHL_X0 = 3;

  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x, input int n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  // Returns {X3,X2,X1,X0}.
  function automatic logic [4*WORD_W-1:0] inv_lt(input logic [WORD_W-1:0] x0_in,
                                                  input logic [WORD_W-1:0] x1_in,
                                                  input logic [WORD_W-1:0] x2_in,
                                                  input logic [WORD_W-1:0] x3_in);
    logic [WORD_W-1:0] x0, x1, x2, x3;
    x0 = x0_in;
    x1 = x1_in;
    x2 = x2_in;
    x3 = x3_in;
    x2 = rotr32(x2, ROT_A);
    x0 = rotr32(x0, ROT_B);
    x2 = x2 ^ x3 ^ (x1 << SHL_X1);
    x0 = x0 ^ x1 ^ x3;
    x3 = rotr32(x3, ROT_C);
    x1 = rotr32(x1, ROT_D);
    x3 = x3 ^ x2 ^ (x0 << SHL_X0);
    x1 = x1 ^ x0 ^ x2;
    x2 = rotr32(x2, ROT_E);
    x0 = rotr32(x0, ROT_F);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [4*WORD_W-1:0] fwd_lt(input logic [WORD_W-1:0] x0_in,
                                                  input logic [WORD_W-1:0] x1_in,
                                                  input logic [WORD_W-1:0] x2_in,
                                                  input logic [WORD_W-1:0] x3_in);
    logic [WORD_W-1:0] x0, x1, x2, x3;
    x0 = rotl32(x0_in, ROT_F);
    x2 = rotl32(x2_in, ROT_E);
    x1 = x1_in ^ x0 ^ x2;
    x3 = x3_in ^ x2 ^ (x0 << SHL_X0);
    x1 = rotl32(x1, ROT_D);
    x3 = rotl32(x3, ROT_C);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << SHL_X1);
    x0 = rotl32(x0, ROT_B);
    x2 = rotl32(x2, ROT_A);
    return {x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/serpent_skid_buf.sv
// Generic 2-entry elastic buffer: main register M drives the outputs, skid
// register S absorbs one beat while M is stalled. Ready is registered.
module serpent_skid_buf #(
  parameter int PAYLOAD_W = 133
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic [PAYLOAD_W-1:0] m_data_q, m_data_d;
  logic [PAYLOAD_W-1:0] s_data_q, s_data_d;
  logic                 m_vld_q, m_vld_d;
  logic                 s_vld_q, s_vld_d;
  logic                 rdy_q;
  logic                 accept;
  logic                 m_leave;

  assign accept  = i_valid & rdy_q;
  assign m_leave = m_vld_q & i_ready;

  // S can only be full while ready is low, so an accept never coincides with S->M.
  always_comb begin
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    m_vld_d  = m_vld_q;
    s_vld_d  = s_vld_q;
    if (i_flush) begin
      m_data_d = '0;
      s_data_d = '0;
      m_vld_d  = 1'b0;
      s_vld_d  = 1'b0;
    end else if (!m_vld_q || m_leave) begin
      if (s_vld_q) begin
        m_data_d = s_data_q;
        m_vld_d  = 1'b1;
        s_data_d = '0;
        s_vld_d  = 1'b0;
      end else if (accept) begin
        m_data_d = i_data;
        m_vld_d  = 1'b1;
      end else begin
        m_data_d = '0;
        m_vld_d  = 1'b0;
      end
    end else if (accept) begin
      s_data_d = i_data;
      s_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_data_q <= '0;
      s_data_q <= '0;
      m_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      m_vld_q  <= m_vld_d;
      s_vld_q  <= s_vld_d;
      rdy_q    <= !s_vld_d;
    end
  end

  assign o_ready = rdy_q;
  assign o_valid = m_vld_q;
  assign o_data  = m_data_q;

endmodule

// File: rtl/serpent_inv_lt_stage.sv
// Front half of a Serpent decryption round: InvLT (or K32 mix on round 31)
// feeding the inverse S-box layer through a registered skid buffer.
module serpent_inv_lt_stage
  import serpent_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int ROUND_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ROUND_W-1:0]    i_round,
  input  logic [4*WORD_W-1:0]   i_key,
  input  logic [WORD_W-1:0]     i_word_0,
  input  logic [WORD_W-1:0]     i_word_1,
  input  logic [WORD_W-1:0]     i_word_2,
  input  logic [WORD_W-1:0]     i_word_3,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WORD_W-1:0]     o_word_0,
  output logic [WORD_W-1:0]     o_word_1,
  output logic [WORD_W-1:0]     o_word_2,
  output logic [WORD_W-1:0]     o_word_3,
  output logic [2:0]            o_sbox_index,
  output logic [ROUND_W-1:0]    o_round,
  output logic [4*WORD_W-1:0]   o_data
);

  localparam int PAYLOAD_W = ROUND_W + 4*WORD_W;

  logic [4*WORD_W-1:0]  xfm_data;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  always_comb begin
    if (i_round == LAST_ROUND) begin
      xfm_data = {i_word_3, i_word_2, i_word_1, i_word_0} ^ i_key;
    end else begin
      xfm_data = inv_lt(i_word_0, i_word_1, i_word_2, i_word_3);
    end
  end

  assign in_payload = {i_round, xfm_data};

  serpent_skid_buf #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (in_payload),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (out_payload)
  );

  // Empty M holds zero, so round/index/words read 0 when nothing is held.
  assign o_data       = out_payload[4*WORD_W-1:0];
  assign o_round      = out_payload[PAYLOAD_W-1:4*WORD_W];
  assign o_sbox_index = o_round[2:0];
  assign o_word_0     = o_data[WORD_W-1:0];
  assign o_word_1     = o_data[2*WORD_W-1:WORD_W];
  assign o_word_2     = o_data[3*WORD_W-1:2*WORD_W];
  assign o_word_3     = o_data[4*WORD_W-1:3*WORD_W];

endmodule

// File: tb/tb_serpent_inv_lt_stage.sv
// Self-checking bench for serpent_inv_lt_stage: queue-based reference model
// plus directed literal checks and randomized traffic.
module tb_serpent_inv_lt_stage;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [4:0]   i_round;
  logic [127:0] i_key;
  logic [31:0]  i_word_0, i_word_1, i_word_2, i_word_3;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [31:0]  o_word_0, o_word_1, o_word_2, o_word_3;
  logic [2:0]   o_sbox_index;
  logic [4:0]   o_round;
  logic [127:0] o_data;

  int tests = 0;
  int fails = 0;
  logic [132:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  serpent_inv_lt_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_round      (i_round),
    .i_key        (i_key),
    .i_word_0     (i_word_0),
    .i_word_1     (i_word_1),
    .i_word_2     (i_word_2),
    .i_word_3     (i_word_3),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_word_0     (o_word_0),
    .o_word_1     (o_word_1),
    .o_word_2     (o_word_2),
    .o_word_3     (o_word_3),
    .o_sbox_index (o_sbox_index),
    .o_round      (o_round),
    .o_data       (o_data)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [127:0] ref_inv_lt(input logic [31:0] a0, a1, a2, a3);
    a2 = ror(a2, 22);
    a0 = ror(a0, 5);
    a2 = a2 ^ a3 ^ (a1 << 7);
    a0 = a0 ^ a1 ^ a3;
    a3 = ror(a3, 7);
    a1 = ror(a1, 1);
    a3 = a3 ^ a2 ^ (a0 << 3);
    a1 = a1 ^ a0 ^ a2;
    a2 = ror(a2, 3);
    a0 = ror(a0, 13);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [132:0] ref_beat(input logic [4:0] r, input logic [127:0] k,
                                            input logic [31:0] a0, a1, a2, a3);
    if (r == 5'd31) return {r, {a3, a2, a1, a0} ^ k};
    return {r, ref_inv_lt(a0, a1, a2, a3)};
  endfunction

  // Compare process: M/S occupancy is the model queue depth.
  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      chk("rst_o_valid", {127'd0, o_valid}, 128'd0);
      chk("rst_o_ready", {127'd0, o_ready}, 128'd1);
      chk("rst_o_data", o_data, 128'd0);
    end else begin
      chk("o_valid", {127'd0, o_valid}, {127'd0, exp_q.size() > 0});
      chk("o_ready", {127'd0, o_ready}, {127'd0, exp_q.size() < 2});
      if (exp_q.size() > 0) begin
        chk("o_data", o_data, exp_q[0][127:0]);
        chk("o_round", {123'd0, o_round}, {123'd0, exp_q[0][132:128]});
        chk("o_sbox_index", {125'd0, o_sbox_index}, {125'd0, exp_q[0][130:128]});
      end else begin
        chk("empty_o_data", o_data, 128'd0);
        chk("empty_o_round", {123'd0, o_round}, 128'd0);
      end
      chk("o_words", {o_word_3, o_word_2, o_word_1, o_word_0}, o_data);
      if (i_flush) begin
        exp_q.delete();
      end else begin
        logic can_acc;
        can_acc = exp_q.size() < 2;
        if (exp_q.size() > 0 && i_ready) void'(exp_q.pop_front());
        if (i_valid && can_acc)
          exp_q.push_back(ref_beat(i_round, i_key, i_word_0, i_word_1, i_word_2, i_word_3));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [127:0] k,
                       input logic [31:0] a0, a1, a2, a3);
    i_valid  = v;
    i_round  = r;
    i_key    = k;
    i_word_0 = a0;
    i_word_1 = a1;
    i_word_2 = a2;
    i_word_3 = a3;
  endtask

  task automatic drive_rand(input logic v, input logic [4:0] r);
    drive(v, r, {$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    logic [132:0] a_exp, b_exp, c_exp;
    i_rst   = 1'b1;
    i_flush = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, 5'd0, 128'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) tick();
    chk("reset_valid", {127'd0, o_valid}, 128'd0);
    chk("reset_ready", {127'd0, o_ready}, 128'd1);
    chk("reset_data", o_data, 128'd0);
    i_rst = 1'b0;
    tick();

    // Known-answer beat, also pins the reference model.
    chk("model_pin", ref_inv_lt(32'd0, 32'd1, 32'd0, 32'd0),
        {32'h00000088, 32'h00000010, 32'h80000081, 32'h00080000});
    drive(1'b1, 5'd5, 128'd0, 32'd0, 32'd1, 32'd0, 32'd0);
    tick();
    i_valid = 1'b0;
    chk("kat_valid", {127'd0, o_valid}, 128'd1);
    chk("kat_w0", {96'd0, o_word_0}, {96'd0, 32'h00080000});
    chk("kat_w1", {96'd0, o_word_1}, {96'd0, 32'h80000081});
    chk("kat_w2", {96'd0, o_word_2}, {96'd0, 32'h00000010});
    chk("kat_w3", {96'd0, o_word_3}, {96'd0, 32'h00000088});
    chk("kat_sbox", {125'd0, o_sbox_index}, 128'd5);
    tick();

    // Key path only on round 31.
    drive(1'b1, 5'd31, {128{1'b1}}, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("k32_data", o_data, {128{1'b1}});
    chk("k32_sbox", {125'd0, o_sbox_index}, 128'd7);
    chk("k32_round", {123'd0, o_round}, 128'd31);
    i_round = 5'd30;
    tick();
    chk("r30_data", o_data, 128'd0);
    chk("r30_round", {123'd0, o_round}, 128'd30);
    i_valid = 1'b0;
    tick();

    // Backpressure: A in M, B in S, C refused until space frees.
    i_ready = 1'b0;
    drive_rand(1'b1, 5'd3);
    a_exp = ref_beat(i_round, i_key, i_word_0, i_word_1, i_word_2, i_word_3);
    tick();
    drive_rand(1'b1, 5'd12);
    b_exp = ref_beat(i_round, i_key, i_word_0, i_word_1, i_word_2, i_word_3);
    tick();
    chk("bp_ready_low", {127'd0, o_ready}, 128'd0);
    chk("bp_hold_a", o_data, a_exp[127:0]);
    drive_rand(1'b1, 5'd31);
    c_exp = ref_beat(i_round, i_key, i_word_0, i_word_1, i_word_2, i_word_3);
    tick();
    chk("bp_c_refused", {127'd0, o_ready}, 128'd0);
    chk("bp_still_a", o_data, a_exp[127:0]);
    i_ready = 1'b1;
    tick();
    chk("bp_b_out", o_data, b_exp[127:0]);
    tick();
    i_valid = 1'b0;
    chk("bp_c_out", o_data, c_exp[127:0]);
    chk("bp_c_round", {123'd0, o_round}, 128'd31);
    tick();
    chk("bp_drained", {127'd0, o_valid}, 128'd0);

    // Full-rate stream, rounds 31..0.
    for (int k = 0; k < 32; k++) begin
      drive_rand(1'b1, 5'(31 - k));
      tick();
      chk("stream_valid", {127'd0, o_valid}, 128'd1);
      chk("stream_sbox", {125'd0, o_sbox_index}, {125'd0, 3'((31 - k) % 8)});
    end
    i_valid = 1'b0;
    tick();

    // Flush with both entries full and a beat offered.
    i_ready = 1'b0;
    drive_rand(1'b1, 5'd9);
    tick();
    drive_rand(1'b1, 5'd10);
    tick();
    chk("pre_flush_ready", {127'd0, o_ready}, 128'd0);
    drive_rand(1'b1, 5'd11);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", {127'd0, o_valid}, 128'd0);
    chk("flush_ready", {127'd0, o_ready}, 128'd1);
    i_ready = 1'b1;
    repeat (3) tick();
    chk("flush_nothing", {127'd0, o_valid}, 128'd0);

    // Async reset mid-stream.
    for (int k = 0; k < 3; k++) begin
      drive_rand(1'b1, 5'($urandom_range(0, 31)));
      tick();
    end
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", {127'd0, o_valid}, 128'd0);
    chk("arst_data", o_data, 128'd0);
    chk("arst_round", {123'd0, o_round}, 128'd0);
    chk("arst_sbox", {125'd0, o_sbox_index}, 128'd0);
    chk("arst_ready", {127'd0, o_ready}, 128'd1);
    i_valid = 1'b0;
    repeat (2) tick();
    i_rst = 1'b0;
    tick();

    // Randomized traffic with random backpressure and rare flushes.
    for (int k = 0; k < 600; k++) begin
      drive_rand(($urandom % 4) != 0, ($urandom % 4 == 0) ? 5'd31 : 5'($urandom));
      i_ready = ($urandom % 3) != 0;
      i_flush = ($urandom % 50) == 0;
      tick();
    end
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick();
    chk("final_empty", {127'd0, o_valid}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
